// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed,
// parameterised response latency.
//
// A load/store request is taken in IDLE, held for WAIT_CYCLES cycles
// in BUSY, then committed against the word array and answered in RESP.
// The response is held until the initiator consumes it.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-low reset
//   req_valid  in   request present
//   req_ready  out  high only in IDLE
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address (word aligned for a legal access)
//   req_wdata  in   store data, little-endian lanes
//   req_be     in   store byte enables (ignored for loads)
//   rsp_valid  out  high only in RESP
//   rsp_ready  in   response consumed
//   rsp_rdata  out  load data; 0 for stores and errors
//   rsp_err    out  misaligned or out-of-range request
//
// state | meaning
// IDLE  | ready for a request
// BUSY  | request captured, wait counter running
// RESP  | response presented, waiting for rsp_ready

module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    // Commit view: with zero wait the request commits on its acceptance
    // edge, so it must come straight from the request port, not the
    // capture registers.
    logic             commit;
    logic             c_we;
    logic [31:0]      c_addr;
    logic [31:0]      c_wdata;
    logic [3:0]       c_be;
    logic             c_err;
    logic [IDX_W-1:0] c_idx;

    always_comb begin
        c_we    = (state_q == IDLE) ? req_we    : we_q;
        c_addr  = (state_q == IDLE) ? req_addr  : addr_q;
        c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
        c_be    = (state_q == IDLE) ? req_be    : be_q;
        c_err   = (c_addr[1:0] != 2'b00) ||
                  ({2'b00, c_addr[31:2]} >= 32'(DEPTH_WORDS));
        c_idx   = c_addr[IDX_W+1:2];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        commit  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = WAIT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                // <= 1 rather than == 1 so a corrupted counter cannot stall
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    commit  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            err_d   = c_err;
            rdata_d = (c_we || c_err) ? 32'h0 : mem_q[c_idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (commit && c_we && !c_err) begin
            for (int b = 0; b < 4; b++) begin
                if (c_be[b]) begin
                    mem_q[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
